// File: rtl/sram_ctrl_pkg.sv
// Shared types and helpers for the TS1DA32KX32 SRAM initiator.
// Optional power-up init walk is enabled by defining SRAM_CTRL_INIT_EN.
package sram_ctrl_pkg;

    localparam int SRAM_AW   = 15;
    localparam int SRAM_DW   = 32;
    localparam int SRAM_NB   = SRAM_DW / 8;
    localparam int RSP_DEPTH = 2;
    localparam int CNT_W     = $clog2(RSP_DEPTH + 1);

    typedef struct packed {
        logic               we;
        logic [SRAM_AW-1:0] addr;
        logic [SRAM_NB-1:0] be;
        logic [SRAM_DW-1:0] wdata;
    } sram_req_t;

    // Macro byte mask is active-low: a 0 bit enables that lane.
    function automatic logic [SRAM_NB-1:0] be_to_bwb(input logic [SRAM_NB-1:0] be);
        return ~be;
    endfunction

endpackage

// File: rtl/sram_ctrl_rsp_buf.sv
// Two-entry in-order read-response FIFO; push and pop may coincide.
module sram_ctrl_rsp_buf
    import sram_ctrl_pkg::*;
#(
    parameter int W = SRAM_DW
) (
    input  logic             CLK,
    input  logic             RSTB,
    input  logic             push_i,
    input  logic [W-1:0]     wdata_i,
    input  logic             pop_i,
    output logic [W-1:0]     rdata_o,
    output logic [CNT_W-1:0] count_o
);

    logic [W-1:0]     mem_q [RSP_DEPTH];
    logic             wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            for (int i = 0; i < RSP_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_d;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/sram_ctrl.sv
// Core-side valid/ready initiator for the TS1DA32KX32 single-port SRAM.
// Define SRAM_CTRL_INIT_EN to fill the array with INIT_VALUE after reset.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int                numAddr    = SRAM_AW,
    parameter int                numOut     = SRAM_DW,
    parameter int                wordDepth  = 32768,
    parameter int                numByte    = SRAM_NB,
    parameter logic [numOut-1:0] INIT_VALUE = '0
) (
    input  logic               CLK,
    input  logic               RSTB,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [numAddr-1:0] req_addr,
    input  logic [numByte-1:0] req_be,
    input  logic [numOut-1:0]  req_wdata,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [numOut-1:0]  rsp_rdata,
    output logic               init_done,
    output logic [numAddr-1:0] A,
    output logic               CEB,
    output logic               OEB,
    output logic               GWEB,
    output logic               BWEB,
    output logic [numByte-1:0] BWB,
    output logic [numOut-1:0]  DIN,
    input  logic [numOut-1:0]  DOUT
);

    sram_req_t        req;
    logic             accept, rd_acc, buf_pop;
    logic             rd_inflight_q, rd_inflight_d;
    logic [CNT_W-1:0] buf_count;
    logic [2:0]       occ;
    logic             init_walk;
    logic [numAddr-1:0] walk_addr;

    assign req = '{we: req_we, addr: req_addr, be: req_be, wdata: req_wdata};

`ifdef SRAM_CTRL_INIT_EN
    localparam logic [numAddr:0] INIT_END = (numAddr + 1)'(wordDepth);
    logic [numAddr:0] init_cnt_q, init_cnt_d;

    assign init_done  = (init_cnt_q == INIT_END);
    assign init_cnt_d = init_done ? init_cnt_q : init_cnt_q + (numAddr + 1)'(1);

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) init_cnt_q <= '0;
        else       init_cnt_q <= init_cnt_d;
    end

    assign init_walk = RSTB & ~init_done;
    assign walk_addr = init_cnt_q[numAddr-1:0];
`else
    assign init_done = 1'b1;
    assign init_walk = 1'b0;
    assign walk_addr = '0;
`endif

    // A same-cycle pop frees its slot, which keeps reads streaming at one per cycle.
    assign buf_pop   = rsp_valid & rsp_ready;
    assign occ       = 3'(buf_count) - 3'(buf_pop) + 3'(rd_inflight_q);
    assign req_ready = RSTB & init_done & (occ < 3'(RSP_DEPTH));
    assign accept    = req_valid & req_ready;
    assign rd_acc    = accept & ~req.we;
    assign rd_inflight_d = rd_acc;

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) rd_inflight_q <= 1'b0;
        else       rd_inflight_q <= rd_inflight_d;
    end

    always_comb begin
        CEB  = 1'b1;
        GWEB = 1'b1;
        BWEB = 1'b1;
        BWB  = '1;
        A    = '0;
        DIN  = '0;
        if (init_walk) begin
            CEB  = 1'b0;
            GWEB = 1'b0;
            BWB  = '0;
            A    = walk_addr;
            DIN  = INIT_VALUE;
        end else if (accept) begin
            if (!req.we) begin
                CEB = 1'b0;
                A   = req.addr;
            end else if (req.be == '1) begin
                CEB  = 1'b0;
                GWEB = 1'b0;
                BWB  = be_to_bwb(req.be);
                A    = req.addr;
                DIN  = req.wdata;
            end else if (req.be != '0) begin
                CEB  = 1'b0;
                BWEB = 1'b0;
                BWB  = be_to_bwb(req.be);
                A    = req.addr;
                DIN  = req.wdata;
            end
        end
    end

    assign OEB = 1'b0;

    sram_ctrl_rsp_buf #(.W(numOut)) u_rsp_buf (
        .CLK     (CLK),
        .RSTB    (RSTB),
        .push_i  (rd_inflight_q),
        .wdata_i (DOUT),
        .pop_i   (buf_pop),
        .rdata_o (rsp_rdata),
        .count_o (buf_count)
    );

    assign rsp_valid = (buf_count != '0);

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl with a behavioural single-port SRAM model.
// Build with SRAM_CTRL_INIT_EN defined to also exercise the init walk.
module tb_sram_ctrl;

    logic        CLK = 1'b0;
    logic        RSTB = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
    logic [14:0] req_addr = '0;
    logic [3:0]  req_be = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid, rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        init_done;
    logic [14:0] A;
    logic        CEB, OEB, GWEB, BWEB;
    logic [3:0]  BWB;
    logic [31:0] DIN, DOUT;

    int checks = 0, errors = 0, cyc = 0, acc_cnt = 0;
    logic [31:0] rq[$];
    int          rc[$];
    logic [31:0] mem [0:63];

    always #5 CLK = ~CLK;

    sram_ctrl #(.wordDepth(16), .INIT_VALUE(32'hA5A5A5A5)) dut (
        .CLK(CLK), .RSTB(RSTB),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .init_done(init_done),
        .A(A), .CEB(CEB), .OEB(OEB), .GWEB(GWEB), .BWEB(BWEB), .BWB(BWB),
        .DIN(DIN), .DOUT(DOUT)
    );

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        DOUT = '0;
    end

    // SRAM model: synchronous read, global or byte-masked write.
    always @(posedge CLK) begin
        if (!CEB) begin
            if (!GWEB) mem[A[5:0]] <= DIN;
            else if (!BWEB) begin
                for (int b = 0; b < 4; b++)
                    if (!BWB[b]) mem[A[5:0]][8*b +: 8] <= DIN[8*b +: 8];
            end else DOUT <= mem[A[5:0]];
        end
    end

    always @(posedge CLK) begin
        cyc++;
        if (req_valid && req_ready) acc_cnt++;
        if (rsp_valid && rsp_ready) begin
            rq.push_back(rsp_rdata);
            rc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [14:0] addr, input logic [3:0] be,
                         input logic [31:0] wd);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_be    = be;
        req_wdata = wd;
    endtask

    task automatic idle();
        @(negedge CLK);
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_be    = '0;
        req_wdata = '0;
    endtask

    // Returns at the posedge on which the driven request is accepted.
    task automatic acc_wait();
        int n = 0;
        #1;
        while (!req_ready && n < 40) begin
            @(negedge CLK);
            #1;
            n++;
        end
        chk("accept_timeout", {31'd0, req_ready}, 32'd1);
        @(posedge CLK);
    endtask

    task automatic wr(input logic [14:0] addr, input logic [3:0] be, input logic [31:0] wd);
        @(negedge CLK);
        drive(1'b1, addr, be, wd);
        acc_wait();
    endtask

    task automatic rd_check(input logic [14:0] addr, input logic [31:0] exp, input string tag);
        rq.delete();
        rc.delete();
        @(negedge CLK);
        drive(1'b0, addr, 4'h0, 32'h0);
        acc_wait();
        idle();
        repeat (3) @(negedge CLK);
        chk({tag, "_count"}, rq.size(), 32'd1);
        chk(tag, (rq.size() > 0) ? rq[0] : 32'hx, exp);
    endtask

    logic [31:0] lane_d [4];
    logic [31:0] exp3 [4];
    logic [31:0] post_rst_exp;
    int          acc_base;

    initial begin
        lane_d = '{32'h0000_00EF, 32'h0000_EF00, 32'h00CD_0000, 32'hAB00_0000};
        exp3   = '{32'hABCD_EFEF, 32'h11, 32'h22, 32'h33};

        // Reset state
        repeat (2) @(negedge CLK);
        req_valid = 1'b1;
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_CEB", {31'd0, CEB}, 32'd1);
        req_valid = 1'b0;
        @(negedge CLK);
        RSTB = 1'b1;

`ifdef SRAM_CTRL_INIT_EN
        // Init walk: 16 busy cycles, then ready
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("init_req_ready", {31'd0, req_ready}, 32'd0);
            chk("init_A", {17'd0, A}, i);
            chk("init_GWEB", {31'd0, GWEB}, 32'd0);
            @(negedge CLK);
        end
        #1;
        chk("init_done", {31'd0, init_done}, 32'd1);
        chk("init_ready", {31'd0, req_ready}, 32'd1);
        rd_check(15'd9, 32'hA5A5A5A5, "init_rd9");
        post_rst_exp = 32'hA5A5A5A5;
`else
        #1;
        chk("init_done_tied", {31'd0, init_done}, 32'd1);
        post_rst_exp = 32'hDEADBEEF;
`endif

        // Test 1: per-lane writes then read
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            drive(1'b1, 15'd0, 4'(1 << i), lane_d[i]);
            #1;
            chk("t1_BWB", {28'd0, BWB}, {28'd0, ~(4'(1 << i))});
            chk("t1_GWEB", {31'd0, GWEB}, 32'd1);
            chk("t1_BWEB", {31'd0, BWEB}, 32'd0);
            acc_wait();
        end
        @(negedge CLK);
        drive(1'b0, 15'd0, 4'h0, 32'h0);
        #1;
        chk("t1_rd_CEB", {31'd0, CEB}, 32'd0);
        chk("t1_rd_BWB", {28'd0, BWB}, 32'hF);
        acc_wait();
        idle();
        @(negedge CLK);
        #1;
        chk("t1_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("t1_rsp_rdata", rsp_rdata, 32'hABCDEFEF);
        @(negedge CLK);
        #1;
        chk("idle_CEB", {31'd0, CEB}, 32'd1);
        chk("idle_A", {17'd0, A}, 32'd0);
        chk("idle_OEB", {31'd0, OEB}, 32'd0);
        chk("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);

        // Test 2: back-to-back reads
        wr(15'd1, 4'hF, 32'h11);
        wr(15'd2, 4'hF, 32'h22);
        wr(15'd3, 4'hF, 32'h33);
        rq.delete();
        rc.delete();
        for (int i = 1; i <= 3; i++) begin
            @(negedge CLK);
            drive(1'b0, 15'(i), 4'h0, 32'h0);
            acc_wait();
        end
        idle();
        repeat (4) @(negedge CLK);
        chk("t2_count", rq.size(), 32'd3);
        if (rq.size() == 3) begin
            for (int i = 0; i < 3; i++) chk("t2_data", rq[i], exp3[i + 1]);
            chk("t2_consec01", rc[1] - rc[0], 32'd1);
            chk("t2_consec12", rc[2] - rc[1], 32'd1);
        end

        // Test 3: backpressure
        @(negedge CLK);
        rsp_ready = 1'b0;
        rq.delete();
        acc_base = acc_cnt;
        drive(1'b0, 15'd0, 4'h0, 32'h0);
        acc_wait();
        @(negedge CLK);
        drive(1'b0, 15'd1, 4'h0, 32'h0);
        acc_wait();
        @(negedge CLK);
        drive(1'b0, 15'd2, 4'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_blocked", {31'd0, req_ready}, 32'd0);
            @(negedge CLK);
        end
        chk("t3_accepted", acc_cnt - acc_base, 32'd2);
        chk("t3_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        rsp_ready = 1'b1;
        acc_wait();
        @(negedge CLK);
        drive(1'b0, 15'd3, 4'h0, 32'h0);
        acc_wait();
        idle();
        repeat (5) @(negedge CLK);
        chk("t3_count", rq.size(), 32'd4);
        if (rq.size() == 4)
            for (int i = 0; i < 4; i++) chk("t3_data", rq[i], exp3[i]);

        // Test 4: full write, then empty-mask write
        @(negedge CLK);
        drive(1'b1, 15'd5, 4'hF, 32'hDEADBEEF);
        #1;
        chk("t4_GWEB", {31'd0, GWEB}, 32'd0);
        chk("t4_BWEB", {31'd0, BWEB}, 32'd1);
        chk("t4_CEB", {31'd0, CEB}, 32'd0);
        acc_wait();
        rd_check(15'd5, 32'hDEADBEEF, "t4_rd5");
        @(negedge CLK);
        drive(1'b1, 15'd5, 4'h0, 32'h12345678);
        #1;
        chk("t4_be0_ready", {31'd0, req_ready}, 32'd1);
        chk("t4_be0_CEB", {31'd0, CEB}, 32'd1);
        acc_wait();
        rd_check(15'd5, 32'hDEADBEEF, "t4_rd5_again");

        // Test 5: reset right after a read accept
        @(negedge CLK);
        drive(1'b0, 15'd5, 4'h0, 32'h0);
        acc_wait();
        #1;
        RSTB = 1'b0;
        #1;
        chk("t5_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("t5_rsp_rdata", rsp_rdata, 32'd0);
        chk("t5_CEB", {31'd0, CEB}, 32'd1);
        chk("t5_A", {17'd0, A}, 32'd0);
        chk("t5_req_ready", {31'd0, req_ready}, 32'd0);
        idle();
        @(negedge CLK);
        RSTB = 1'b1;
        rq.delete();
        repeat (3) @(negedge CLK);
        chk("t5_no_stale", rq.size(), 32'd0);
        chk("t5_rsp_valid_after", {31'd0, rsp_valid}, 32'd0);
        rd_check(15'd5, post_rst_exp, "t5_rd5");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
